// File: rtl/amo_engine.sv
// -----------------------------------------------------------------------------
// amo_engine
//
// Atomic memory operation engine. It accepts one AMO request at a time, reads
// the old value from memory, computes op(old, rs2), writes the result back,
// and returns the old value on the response channel.
//
// Optional feature macro: AMO_LRSC_EN
//   When defined, LR/SC are supported with a single reservation register
//   covering a 2**RSV_GRAN_BITS byte granule. When undefined, LR and SC are
//   rejected as invalid ops and no reservation state exists.
//
// Memory-side assumption: for word ops the memory returns the addressed
// 32-bit word in mem_resp_rdata[31:0], and a word write carries its data in
// mem_req_wdata[31:0] with mem_req_size=1.
//
// Ports
//   clk, reset          clock (rising edge) / asynchronous active-high reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_op              0 SWAP,1 ADD,2 XOR,3 AND,4 OR,5 MIN,6 MAX,7 MINU,
//                       8 MAXU,9 LR,10 SC; others invalid
//   req_width_32        1 = word op, 0 = doubleword op
//   req_addr, req_data  byte address and rs2 operand
//   mem_req_*           memory request (held until mem_req_ready)
//   mem_resp_valid      read data valid / write acknowledge
//   mem_resp_rdata      read data
//   resp_valid/ready    response handshake, resp_data/resp_err held stable
//   snoop_valid/addr    external write/invalidate that kills the reservation
// -----------------------------------------------------------------------------
module amo_engine #(
    parameter int RSV_GRAN_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_width_32,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_write,
    output logic [63:0] mem_req_addr,
    output logic [63:0] mem_req_wdata,
    output logic        mem_req_size,
    input  logic        mem_resp_valid,
    input  logic [63:0] mem_resp_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic        resp_err,
    input  logic        snoop_valid,
    input  logic [63:0] snoop_addr
);

    localparam logic [3:0] OP_SWAP = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_MIN  = 4'd5;
    localparam logic [3:0] OP_MAX  = 4'd6;
    localparam logic [3:0] OP_MINU = 4'd7;
    localparam logic [3:0] OP_MAXU = 4'd8;
    localparam logic [3:0] OP_LR   = 4'd9;
    localparam logic [3:0] OP_SC   = 4'd10;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;

    function automatic logic [63:0] sext32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    // Word ops compare on extended low halves and write back only the low
    // 32 bits (upper half zero).
    function automatic logic [63:0] amo_alu(input logic [3:0]  op,
                                            input logic        w32,
                                            input logic [63:0] old,
                                            input logic [63:0] rs2);
        logic signed [63:0] a_s;
        logic signed [63:0] b_s;
        logic        [63:0] a_u;
        logic        [63:0] b_u;
        logic        [63:0] res;
        a_s = w32 ? sext32(old[31:0]) : old;
        b_s = w32 ? sext32(rs2[31:0]) : rs2;
        a_u = w32 ? {32'd0, old[31:0]} : old;
        b_u = w32 ? {32'd0, rs2[31:0]} : rs2;
        res = rs2;
        case (op)
            OP_SWAP: res = rs2;
            OP_ADD:  res = old + rs2;
            OP_XOR:  res = old ^ rs2;
            OP_AND:  res = old & rs2;
            OP_OR:   res = old | rs2;
            OP_MIN:  res = (a_s < b_s) ? old : rs2;
            OP_MAX:  res = (a_s > b_s) ? old : rs2;
            OP_MINU: res = (a_u < b_u) ? old : rs2;
            OP_MAXU: res = (a_u > b_u) ? old : rs2;
            default: res = rs2;
        endcase
        return w32 ? {32'd0, res[31:0]} : res;
    endfunction

    // Latched request (p0) and computed write/response data (p1)
    logic [3:0]  op_p0;
    logic        w32_p0;
    logic [63:0] addr_p0;
    logic [63:0] data_p0;
    logic [63:0] wdata_p1;
    logic [63:0] rdata_p1;
    logic        err_p1;

    logic        accept;
    logic        misaligned;
    logic        op_invalid;
    logic        bad;
    logic        sc_ok;
    logic        rd_capture;
    logic [63:0] old_ext;

    assign accept     = (state == IDLE) && req_valid;
    assign misaligned = req_width_32 ? (req_addr[1:0] != 2'd0) : (req_addr[2:0] != 3'd0);
`ifdef AMO_LRSC_EN
    assign op_invalid = (req_op > OP_SC);
`else
    assign op_invalid = (req_op > OP_MAXU);
`endif
    assign bad        = misaligned || op_invalid;
    assign rd_capture = (state == RD_WAIT) && mem_resp_valid;
    assign old_ext    = w32_p0 ? sext32(mem_resp_rdata[31:0]) : mem_resp_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_write = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad) begin
                        state_nxt = RESP;
                    end else if (req_op == OP_SC) begin
                        state_nxt = sc_ok ? WR_REQ : RESP;
                    end else begin
                        state_nxt = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = (op_p0 == OP_LR) ? RESP : WR_REQ;
                end
            end
            WR_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_write = 1'b1;
                if (mem_req_ready) begin
                    state_nxt = WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (mem_resp_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: request capture on accept; stage p1: memory data capture
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= req_op;
            w32_p0   <= req_width_32;
            addr_p0  <= req_addr;
            data_p0  <= req_data;
            err_p1   <= bad;
            // Failed SC returns 1; error and successful SC return 0.
            rdata_p1 <= (!bad && (req_op == OP_SC) && !sc_ok) ? 64'd1 : 64'd0;
            wdata_p1 <= req_width_32 ? {32'd0, req_data[31:0]} : req_data;
        end
        if (rd_capture) begin
            rdata_p1 <= old_ext;
            wdata_p1 <= amo_alu(op_p0, w32_p0, mem_resp_rdata, data_p0);
        end
    end

    // Data outputs are gated by state so every output reads 0 outside its
    // valid window, including straight out of reset.
    assign mem_req_addr  = mem_req_valid ? addr_p0 : 64'd0;
    assign mem_req_wdata = mem_req_write ? wdata_p1 : 64'd0;
    assign mem_req_size  = mem_req_valid & w32_p0;
    assign resp_data     = resp_valid ? rdata_p1 : 64'd0;
    assign resp_err      = resp_valid & err_p1;

`ifdef AMO_LRSC_EN
    localparam int RA_W = 64 - RSV_GRAN_BITS;

    logic            rsv_vld;
    logic [RA_W-1:0] rsv_addr;
    logic [RA_W-1:0] req_gran;
    logic [RA_W-1:0] snoop_gran;
    logic [RA_W-1:0] lr_gran;
    logic            lr_capture;
    logic            sc_accept;
    logic            unused_snoop_lo;

    assign req_gran        = req_addr[63:RSV_GRAN_BITS];
    assign snoop_gran      = snoop_addr[63:RSV_GRAN_BITS];
    assign lr_gran         = addr_p0[63:RSV_GRAN_BITS];
    assign sc_ok           = rsv_vld && (rsv_addr == req_gran);
    assign lr_capture      = rd_capture && (op_p0 == OP_LR);
    assign sc_accept       = accept && !bad && (req_op == OP_SC);
    assign unused_snoop_lo = ^snoop_addr[RSV_GRAN_BITS-1:0];

    // A snoop to the LR granule in the capture cycle wins over the set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsv_vld <= 1'b0;
        end else if (lr_capture) begin
            rsv_vld <= !(snoop_valid && (snoop_gran == lr_gran));
        end else if (sc_accept || (snoop_valid && (snoop_gran == rsv_addr))) begin
            rsv_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (lr_capture) begin
            rsv_addr <= lr_gran;
        end
    end
`else
    logic        unused_lrsc;
    logic [31:0] unused_gran;

    assign sc_ok       = 1'b0;
    assign unused_gran = 32'(RSV_GRAN_BITS);
    assign unused_lrsc = ^{snoop_valid, snoop_addr, unused_gran};
`endif

endmodule

// File: tb/tb_amo_engine.sv
module tb_amo_engine;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic        req_width_32;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_write;
    logic [63:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic        mem_req_size;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        resp_err;
    logic        snoop_valid;
    logic [63:0] snoop_addr;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model controls (written by tests) and observations (written by model)
    logic [63:0] mem_value    = 64'd0;
    int          ready_delay  = 0;
    logic        hold_wr_resp = 1'b0;
    int          inject_req   = 0;
    int          inject_done  = 0;
    int          rd_cnt       = 0;
    int          wr_cnt       = 0;
    logic [63:0] last_rd_addr = 64'd0;
    logic [63:0] last_wr_addr = 64'd0;
    logic [63:0] last_wr_data = 64'd0;
    logic        last_wr_size = 1'b0;

    typedef struct {
        logic [3:0]  op;
        logic        w32;
        logic [63:0] mem;
        logic [63:0] rs2;
        logic [63:0] wr;
        logic [63:0] rsp;
    } vec_t;

    amo_engine #(.RSV_GRAN_BITS(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_width_32   (req_width_32),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_size   (mem_req_size),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .snoop_valid    (snoop_valid),
        .snoop_addr     (snoop_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: accepts a request after ready_delay cycles and
    // answers one cycle after the handshake.
    initial begin
        logic        wr;
        logic [63:0] a;
        logic [63:0] wd;
        logic        sz;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 64'd0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_resp_rdata = 64'd0;
            if (inject_req != inject_done) begin
                inject_done    = inject_done + 1;
                mem_resp_valid = 1'b1;
                mem_resp_rdata = 64'h0000_0000_0000_0BAD;
            end else if (mem_req_valid) begin
                for (int i = 0; i < ready_delay; i++) @(negedge clk);
                mem_req_ready = 1'b1;
                wr = mem_req_write;
                a  = mem_req_addr;
                wd = mem_req_wdata;
                sz = mem_req_size;
                @(posedge clk);
                if (wr) begin
                    wr_cnt       = wr_cnt + 1;
                    last_wr_addr = a;
                    last_wr_data = wd;
                    last_wr_size = sz;
                end else begin
                    rd_cnt       = rd_cnt + 1;
                    last_rd_addr = a;
                end
                @(negedge clk);
                mem_req_ready = 1'b0;
                if (!(wr && hold_wr_resp)) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = wr ? 64'd0 : mem_value;
                end
            end
        end
    end

    task automatic do_req(input  logic [3:0]  op,
                          input  logic        w32,
                          input  logic [63:0] addr,
                          input  logic [63:0] data,
                          input  int          resp_delay,
                          output logic [63:0] rdata,
                          output logic        err,
                          output logic [63:0] rdata2,
                          output logic        to,
                          output logic        first_vld,
                          output logic        first_wr);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_op       = op;
        req_width_32 = w32;
        req_addr     = addr;
        req_data     = data;
        @(negedge clk);
        req_valid = 1'b0;
        first_vld = mem_req_valid;
        first_wr  = mem_req_write;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        to     = !resp_valid;
        rdata  = resp_data;
        err    = resp_err;
        for (int i = 0; i < resp_delay; i++) @(negedge clk);
        rdata2 = resp_data;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        n_checks++;
        if ({mem_req_valid, mem_req_write, mem_req_size, resp_valid, resp_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl_outputs: got %b expected 00000",
                     {mem_req_valid, mem_req_write, mem_req_size, resp_valid, resp_err});
        end
        n_checks++;
        if ({mem_req_addr, mem_req_wdata, resp_data} !== 192'd0) begin
            n_fail++;
            $display("FAIL reset_data_outputs: got %h %h %h expected zeros",
                     mem_req_addr, mem_req_wdata, resp_data);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add_double;
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        int          r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        mem_value = 64'd5;
        do_req(4'd1, 1'b0, 64'h1000, 64'd7, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL add_timeout: no response within budget");
        end
        n_checks++;
        if ({fv, fw} !== 2'b10) begin
            n_fail++;
            $display("FAIL add_first_mem_req: got valid/write %b expected 10", {fv, fw});
        end
        n_checks++;
        if (last_rd_addr !== 64'h1000 || rd_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL add_read: got addr %h count %0d expected 1000 count 1", last_rd_addr, rd_cnt - r0);
        end
        n_checks++;
        if (last_wr_addr !== 64'h1000 || last_wr_data !== 64'd12 || last_wr_size !== 1'b0 || wr_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL add_write: got addr %h data %h size %b count %0d expected 1000 c 0 1",
                     last_wr_addr, last_wr_data, last_wr_size, wr_cnt - w0);
        end
        n_checks++;
        if (rd !== 64'd5 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL add_resp: got data %h err %b expected 5 err 0", rd, er);
        end
    endtask

    task automatic test_min_word;
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        mem_value = 64'hDEAD_BEEF_8000_0000;
        do_req(4'd5, 1'b1, 64'h1004, 64'd1, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0) begin
            n_fail++;
            $display("FAIL min_word_timeout: no response within budget");
        end
        n_checks++;
        if (last_wr_data !== 64'h0000_0000_8000_0000 || last_wr_size !== 1'b1 || last_wr_addr !== 64'h1004) begin
            n_fail++;
            $display("FAIL min_word_write: got data %h size %b addr %h expected 80000000 1 1004",
                     last_wr_data, last_wr_size, last_wr_addr);
        end
        n_checks++;
        if (rd !== 64'hFFFF_FFFF_8000_0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL min_word_resp: got %h err %b expected ffffffff80000000 err 0", rd, er);
        end
    endtask

    task automatic test_ops;
        vec_t        v[11];
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        int          w0;
        v[0]  = '{4'd0, 1'b0, 64'h1111, 64'hABCD, 64'hABCD, 64'h1111};
        v[1]  = '{4'd2, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 64'hF0F0};
        v[2]  = '{4'd3, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 64'hF0F0};
        v[3]  = '{4'd4, 1'b0, 64'hF0F0, 64'hFF00, 64'hFFF0, 64'hF0F0};
        v[4]  = '{4'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        v[5]  = '{4'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF};
        v[6]  = '{4'd8, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        v[7]  = '{4'd1, 1'b1, 64'h0000_0001_FFFF_FFFF, 64'd2, 64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        v[8]  = '{4'd8, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_0000_0001, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000};
        v[9]  = '{4'd5, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE, 64'h0000_0000_7FFF_FFFF};
        v[10] = '{4'd6, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 64'h8000_0000_0000_0000};
        for (int i = 0; i < 11; i++) begin
            w0 = wr_cnt;
            mem_value = v[i].mem;
            do_req(v[i].op, v[i].w32, 64'h3000, v[i].rs2, 0, rd, er, rd2, to, fv, fw);
            n_checks++;
            if (to !== 1'b0 || wr_cnt - w0 !== 1) begin
                n_fail++;
                $display("FAIL op%0d_flow: timeout %b writes %0d expected 0 and 1", i, to, wr_cnt - w0);
            end
            n_checks++;
            if (last_wr_data !== v[i].wr || last_wr_size !== v[i].w32) begin
                n_fail++;
                $display("FAIL op%0d_wdata: got %h size %b expected %h size %b",
                         i, last_wr_data, last_wr_size, v[i].wr, v[i].w32);
            end
            n_checks++;
            if (rd !== v[i].rsp || er !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_resp: got %h err %b expected %h err 0", i, rd, er, v[i].rsp);
            end
        end
    endtask

    task automatic test_errors;
        logic [3:0]  ops[4];
        logic        w32s[4];
        logic [63:0] addrs[4];
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        int          r0, w0;
        ops[0] = 4'd1;  w32s[0] = 1'b0; addrs[0] = 64'h1004;
        ops[1] = 4'd1;  w32s[1] = 1'b1; addrs[1] = 64'h1002;
        ops[2] = 4'd11; w32s[2] = 1'b0; addrs[2] = 64'h1000;
        ops[3] = 4'd15; w32s[3] = 1'b1; addrs[3] = 64'h1000;
        for (int i = 0; i < 4; i++) begin
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(ops[i], w32s[i], addrs[i], 64'd7, 0, rd, er, rd2, to, fv, fw);
            n_checks++;
            if (to !== 1'b0 || fv !== 1'b0 || rd_cnt != r0 || wr_cnt != w0) begin
                n_fail++;
                $display("FAIL err%0d_no_mem: timeout %b memvalid %b reads %0d writes %0d expected 0 0 0 0",
                         i, to, fv, rd_cnt - r0, wr_cnt - w0);
            end
            n_checks++;
            if (er !== 1'b1 || rd !== 64'd0) begin
                n_fail++;
                $display("FAIL err%0d_resp: got err %b data %h expected err 1 data 0", i, er, rd);
            end
        end
    endtask

    task automatic test_lrsc;
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        int          r0, w0;
`ifdef AMO_LRSC_EN
        mem_value = 64'h0000_0000_0000_0055;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd9, 1'b0, 64'h2000, 64'd0, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'h55 || er !== 1'b0 || rd_cnt - r0 !== 1 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL lr_read: got data %h err %b reads %0d writes %0d expected 55 0 1 0",
                     rd, er, rd_cnt - r0, wr_cnt - w0);
        end
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd10, 1'b0, 64'h2008, 64'd9, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'd0 || er !== 1'b0 || wr_cnt - w0 !== 1 || rd_cnt != r0 ||
            last_wr_addr !== 64'h2008 || last_wr_data !== 64'd9) begin
            n_fail++;
            $display("FAIL sc_success: got data %h err %b writes %0d wr %h/%h expected 0 0 1 2008/9",
                     rd, er, wr_cnt - w0, last_wr_addr, last_wr_data);
        end
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd10, 1'b0, 64'h2008, 64'd9, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'd1 || er !== 1'b0 || wr_cnt != w0 || rd_cnt != r0) begin
            n_fail++;
            $display("FAIL sc_second: got data %h err %b mem reqs %0d expected 1 0 0",
                     rd, er, (wr_cnt - w0) + (rd_cnt - r0));
        end
        do_req(4'd9, 1'b0, 64'h2000, 64'd0, 0, rd, er, rd2, to, fv, fw);
        @(negedge clk);
        snoop_valid = 1'b1;
        snoop_addr  = 64'h2030;
        @(negedge clk);
        snoop_valid = 1'b0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd10, 1'b0, 64'h2000, 64'd9, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'd1 || wr_cnt != w0 || rd_cnt != r0) begin
            n_fail++;
            $display("FAIL sc_after_snoop: got data %h writes %0d expected 1 0", rd, wr_cnt - w0);
        end
`else
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd9, 1'b0, 64'h2000, 64'd0, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || er !== 1'b1 || rd !== 64'd0 || rd_cnt != r0 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL lr_disabled: got err %b data %h mem reqs %0d expected 1 0 0",
                     er, rd, (rd_cnt - r0) + (wr_cnt - w0));
        end
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(4'd10, 1'b0, 64'h2000, 64'd9, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || er !== 1'b1 || rd !== 64'd0 || rd_cnt != r0 || wr_cnt != w0) begin
            n_fail++;
            $display("FAIL sc_disabled: got err %b data %h mem reqs %0d expected 1 0 0",
                     er, rd, (rd_cnt - r0) + (wr_cnt - w0));
        end
`endif
    endtask

    task automatic test_stray_resp;
        logic saw;
        saw = 1'b0;
        inject_req = inject_req + 1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_req_valid || !req_ready) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_resp_idle: got activity %b expected 0", saw);
        end
    endtask

    task automatic test_reset_midop;
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        logic        saw;
        int          n, w0;
        hold_wr_resp = 1'b1;
        mem_value = 64'd5;
        w0 = wr_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'd1; req_width_32 = 1'b0;
        req_addr = 64'h1000; req_data = 64'd7;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (wr_cnt == w0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (wr_cnt == w0) begin
            n_fail++;
            $display("FAIL midop_reach_wr_wait: got no write handshake expected one");
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || resp_data !== 64'd0) begin
            n_fail++;
            $display("FAIL midop_reset_outputs: got ready %b memvalid %b respvalid %b data %h expected 1 0 0 0",
                     req_ready, mem_req_valid, resp_valid, resp_data);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold_wr_resp = 1'b0;
        inject_req = inject_req + 1;
        saw = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid || mem_req_valid || !req_ready) saw = 1'b1;
        end
        n_checks++;
        if (saw !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_late_resp: got activity %b expected 0", saw);
        end
        mem_value = 64'd20;
        do_req(4'd1, 1'b0, 64'h1008, 64'd3, 0, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'd20 || er !== 1'b0 || last_wr_data !== 64'd23 || last_wr_addr !== 64'h1008) begin
            n_fail++;
            $display("FAIL midop_next_req: got data %h err %b wr %h/%h expected 14 0 1008/17",
                     rd, er, last_wr_addr, last_wr_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] rd, rd2;
        logic        er, to, fv, fw;
        ready_delay = 2;
        mem_value = 64'h0000_0000_0000_0100;
        do_req(4'd1, 1'b0, 64'h4000, 64'h0000_0000_0000_0011, 3, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'h100 || rd2 !== 64'h100 || last_wr_data !== 64'h111) begin
            n_fail++;
            $display("FAIL b2b_first: got data %h held %h wdata %h expected 100 100 111", rd, rd2, last_wr_data);
        end
        mem_value = 64'h0000_0000_0000_00F0;
        do_req(4'd2, 1'b0, 64'h4008, 64'h0000_0000_0000_00FF, 2, rd, er, rd2, to, fv, fw);
        n_checks++;
        if (to !== 1'b0 || rd !== 64'hF0 || rd2 !== 64'hF0 || last_wr_data !== 64'h0F || last_wr_addr !== 64'h4008) begin
            n_fail++;
            $display("FAIL b2b_second: got data %h held %h wr %h/%h expected f0 f0 4008/f", rd, rd2,
                     last_wr_addr, last_wr_data);
        end
        ready_delay = 0;
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = 4'd0;
        req_width_32 = 1'b0;
        req_addr     = 64'd0;
        req_data     = 64'd0;
        resp_ready   = 1'b0;
        snoop_valid  = 1'b0;
        snoop_addr   = 64'd0;
        test_reset();
        test_add_double();
        test_min_word();
        test_ops();
        test_errors();
        test_lrsc();
        test_stray_resp();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
